alarm_sequencer: RTL

Controller in front of the square-wave alarm tone generator. Arbitrates several alarm sources onto the generator's single tone-enable input, using fixed priority. Gates the tone into a per-source beep cadence (source i emits i+1 beeps per burst) so alarms are audibly distinguishable. Also handles operator silencing.

---
 rtl/alarm_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: fixed-priority alarm arbiter that gates the tone generator into per-source beep bursts.
// Define ALARM_SNOOZE_EN to add the snooze input, SNOOZE_TICKS parameter and SNOOZE state.
module alarm_sequencer #(
    parameter int NUM_SRC   = 4,
    parameter int TICK_DIV  = 1000,
    parameter int ON_TICKS  = 50,
    parameter int OFF_TICKS = 50,
    parameter int GAP_TICKS = 200
`ifdef ALARM_SNOOZE_EN
    ,
    parameter int SNOOZE_TICKS = 3000
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] ack,
`ifdef ALARM_SNOOZE_EN
    input  logic               snooze,
`endif
    output logic               tone_en,
    output logic [NUM_SRC-1:0] grant,
    output logic               busy
);

`ifdef ALARM_SNOOZE_EN
    localparam int SNZ_TICKS = SNOOZE_TICKS;
`else
    localparam int SNZ_TICKS = 1;
`endif
    localparam int MAX_A     = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAX_B     = (GAP_TICKS > SNZ_TICKS) ? GAP_TICKS : SNZ_TICKS;
    localparam int MAX_TICKS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW        = $clog2(MAX_TICKS + 1);
    localparam int PW        = $clog2(TICK_DIV + 1);
    localparam int BW        = $clog2(NUM_SRC + 1);
    localparam int IW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] SNZ_LAST   = TW'(SNZ_TICKS - 1);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [2:0] {ST_IDLE, ST_ON, ST_OFF, ST_GAP, ST_SNOOZE} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_ON, ST_OFF, ST_GAP} state_t;
`endif

    state_t             state_reg;
    logic               tone_en_reg;
    logic               busy_reg;
    logic [NUM_SRC-1:0] grant_reg;
    logic [IW-1:0]      grant_idx_reg;
    logic [BW-1:0]      beep_cnt_reg;
    logic [PW-1:0]      presc_reg;
    logic [TW-1:0]      tick_cnt_reg;

    logic [NUM_SRC-1:0] silenced;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] winner_onehot;
    logic [IW-1:0]      winner_idx;
    logic               winner_found;
    logic               granted_ok;
    logic               others_ok;
    logic               more_beeps;
    logic               tick;
    logic [TW-1:0]      phase_last;
    logic               phase_done;

    // An ack in the same cycle already counts as silencing, so it blocks a grant on that edge.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic sil_reg;
        always_ff @(posedge clk) begin
            if (rst || !req[gi]) begin
                sil_reg <= 1'b0;
            end else if (ack[gi]) begin
                sil_reg <= 1'b1;
            end
        end
        assign silenced[gi] = sil_reg;
        assign eligible[gi] = req[gi] & ~sil_reg & ~ack[gi];
    end

    always_comb begin
        winner_found = 1'b0;
        winner_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner_found = 1'b1;
                winner_idx   = IW'(i);
            end
        end
    end

    assign winner_onehot = NUM_SRC'(1) << winner_idx;
    assign granted_ok    = eligible[grant_idx_reg];
    assign others_ok     = |(eligible & ~grant_reg);
    assign more_beeps    = int'(beep_cnt_reg) <= int'(grant_idx_reg);
    assign tick          = (presc_reg == PRESC_LAST);

    always_comb begin
        phase_last = ON_LAST;
        case (state_reg)
            ST_OFF:    phase_last = OFF_LAST;
            ST_GAP:    phase_last = GAP_LAST;
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: phase_last = SNZ_LAST;
`endif
            default:   phase_last = ON_LAST;
        endcase
    end

    assign phase_done = tick && (tick_cnt_reg == phase_last);

    // Every branch that changes state also clears the prescaler and tick counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            tone_en_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            grant_reg     <= '0;
            grant_idx_reg <= '0;
            beep_cnt_reg  <= '0;
            presc_reg     <= '0;
            tick_cnt_reg  <= '0;
        end else begin
            if (tick) begin
                presc_reg    <= '0;
                tick_cnt_reg <= tick_cnt_reg + TW'(1);
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end
`ifdef ALARM_SNOOZE_EN
            if (snooze && state_reg != ST_IDLE) begin
                state_reg    <= ST_SNOOZE;
                tone_en_reg  <= 1'b0;
                busy_reg     <= 1'b1;
                grant_reg    <= '0;
                presc_reg    <= '0;
                tick_cnt_reg <= '0;
            end else
`endif
            begin
                unique case (state_reg)
                    ST_IDLE: begin
                        presc_reg    <= '0;
                        tick_cnt_reg <= '0;
                        if (winner_found) begin
                            state_reg     <= ST_ON;
                            tone_en_reg   <= 1'b1;
                            busy_reg      <= 1'b1;
                            grant_reg     <= winner_onehot;
                            grant_idx_reg <= winner_idx;
                            beep_cnt_reg  <= '0;
                        end
                    end
                    ST_ON, ST_OFF: begin
                        if (!granted_ok) begin
                            // Abort the burst: skip to GAP only if someone else is waiting.
                            tone_en_reg  <= 1'b0;
                            presc_reg    <= '0;
                            tick_cnt_reg <= '0;
                            if (others_ok) begin
                                state_reg <= ST_GAP;
                            end else begin
                                state_reg <= ST_IDLE;
                                busy_reg  <= 1'b0;
                                grant_reg <= '0;
                            end
                        end else if (phase_done) begin
                            presc_reg    <= '0;
                            tick_cnt_reg <= '0;
                            if (state_reg == ST_ON) begin
                                state_reg    <= ST_OFF;
                                tone_en_reg  <= 1'b0;
                                beep_cnt_reg <= beep_cnt_reg + BW'(1);
                            end else if (more_beeps) begin
                                state_reg   <= ST_ON;
                                tone_en_reg <= 1'b1;
                            end else begin
                                state_reg <= ST_GAP;
                            end
                        end
                    end
`ifdef ALARM_SNOOZE_EN
                    ST_GAP, ST_SNOOZE: begin
`else
                    ST_GAP: begin
`endif
                        if (phase_done) begin
                            presc_reg     <= '0;
                            tick_cnt_reg  <= '0;
                            beep_cnt_reg  <= '0;
                            grant_idx_reg <= winner_idx;
                            if (winner_found) begin
                                state_reg   <= ST_ON;
                                tone_en_reg <= 1'b1;
                                busy_reg    <= 1'b1;
                                grant_reg   <= winner_onehot;
                            end else begin
                                state_reg   <= ST_IDLE;
                                tone_en_reg <= 1'b0;
                                busy_reg    <= 1'b0;
                                grant_reg   <= '0;
                            end
                        end
                    end
                    default: begin
                        state_reg   <= ST_IDLE;
                        tone_en_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        grant_reg   <= '0;
                    end
                endcase
            end
        end
    end

    assign tone_en = tone_en_reg;
    assign grant   = grant_reg;
    assign busy    = busy_reg;

endmodule
